// File: rtl/store_drain_ctrl.sv
// store_drain_ctrl: arbitrates the single L1-D port between load-miss requests and store-buffer drain.
// Define STORE_DRAIN_STARVE_GUARD_EN to bound consecutive load wins while a store is pending.
module store_drain_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        sb_head_valid,
    input  logic [15:0] sb_head_addr,
    input  logic [15:0] sb_head_data,
    output logic        sb_pop_head,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    output logic        ld_grant,
    input  logic        drain_all,
    output logic        drain_busy,
    output logic        drain_done,
    output logic        dc_req,
    output logic        dc_we,
    output logic [15:0] dc_addr,
    output logic [15:0] dc_wdata,
    input  logic        dc_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_WAIT = 2'd2,
        POP     = 2'd3
    } state_t;

`ifdef STORE_DRAIN_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic        dc_req_q;
    logic        dc_we_q;
    logic        pop_q;
    logic        grant_q;
    logic        busy_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;
    logic        force_store;
    logic        take_load;

    // With the guard compiled out the counter is held at zero and folds away.
    assign force_store = GUARD_EN && (starve_q >= LIMIT);
    assign take_load   = (state_q == IDLE) && ld_req && !drain_all && !force_store;

    always_comb begin
        // NOTE: default assignment first so every path drives starve_d and no latch is inferred.
        starve_d = starve_q;
        if (!GUARD_EN || !sb_head_valid) begin
            starve_d = '0;
        end else if (state_q == IDLE) begin
            starve_d = take_load ? (starve_q + 4'd1) : 4'd0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            dc_req_q <= 1'b0;
            dc_we_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pop_q    <= 1'b0;
            grant_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            pop_q   <= 1'b0;
            grant_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_load) begin
                        state_q  <= LD_WAIT;
                        dc_req_q <= 1'b1;
                        dc_we_q  <= 1'b0;
                        addr_q   <= ld_addr;
                    end else if (sb_head_valid) begin
                        state_q  <= ST_WAIT;
                        dc_req_q <= 1'b1;
                        dc_we_q  <= 1'b1;
                        addr_q   <= sb_head_addr;
                        wdata_q  <= sb_head_data;
                        busy_q   <= 1'b1;
                    end
                end
                LD_WAIT: begin
                    if (dc_ack) begin
                        state_q  <= IDLE;
                        dc_req_q <= 1'b0;
                        grant_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dc_ack) begin
                        state_q  <= POP;
                        dc_req_q <= 1'b0;
                        dc_we_q  <= 1'b0;
                        pop_q    <= 1'b1;
                    end
                end
                // The head still shows the retiring entry here, so no arbitration.
                POP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dc_req      = dc_req_q;
    assign dc_we       = dc_we_q;
    assign dc_addr     = addr_q;
    assign dc_wdata    = wdata_q;
    assign sb_pop_head = pop_q;
    assign ld_grant    = grant_q;
    assign drain_busy  = busy_q;

    // drain_done qualifies the registered idle state with the live fence and head inputs.
    assign drain_done  = !RST && (state_q == IDLE) && drain_all && !sb_head_valid;

endmodule

// File: doc/store_drain_ctrl.md
STORE_DRAIN_CTRL -- requirements
Module: store_drain_ctrl

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive load grants while a store is pending (range 1..15).
REQ-002 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports sb_head_valid in 1, sb_head_addr in 16, sb_head_data in 16: store buffer head entry is retired, executed and ready to write.
REQ-005 SHALL have port sb_pop_head  output  1  one-cycle pop strobe to the store buffer.
REQ-006 SHALL have ports ld_req in 1, ld_addr in 16: load-miss cache access request, held until ld_grant.
REQ-007 SHALL have port ld_grant  output  1  one-cycle pulse, load access completed.
REQ-008 SHALL have port drain_all  input  1  fence/flush request, level-held until drain_done.
REQ-009 SHALL have ports drain_busy out 1 (a store access is in flight) and drain_done out 1 (drain_all high, idle, no head valid).
REQ-010 SHALL have ports dc_req out 1, dc_we out 1, dc_addr out 16, dc_wdata out 16: single L1-D port request.
REQ-011 SHALL have port dc_ack  input  1  cache accepts/completes the request on the cycle it is high.

Function
REQ-012 SHALL implement FSM states IDLE, LD_WAIT, ST_WAIT, POP; all outputs registered.
REQ-013 IDLE: if ld_req and !drain_all and !force_store -> LD_WAIT; dc_req=1, dc_we=0, dc_addr=ld_addr captured.
REQ-014 IDLE otherwise, if sb_head_valid -> ST_WAIT; dc_req=1, dc_we=1, dc_addr/dc_wdata captured from head.
REQ-015 IDLE with neither request: dc_req=0, stay IDLE.
REQ-016 LD_WAIT/ST_WAIT: dc_req, dc_we, dc_addr, dc_wdata SHALL hold stable until the cycle dc_ack=1.
REQ-017 LD_WAIT on dc_ack: next cycle dc_req=0, ld_grant=1 for exactly one cycle, state IDLE.
REQ-018 ST_WAIT on dc_ack: next cycle dc_req=0, state POP, sb_pop_head=1 for exactly one cycle; then IDLE.
REQ-019 Minimum store occupancy: request-to-pop 2 cycles with ack on first request cycle; one store per 3 cycles max.
REQ-020 No new arbitration SHALL occur in POP (head not yet updated); dc_ack in IDLE/POP SHALL be ignored.
REQ-021 drain_busy SHALL be 1 in ST_WAIT and POP, else 0.
REQ-022 drain_done SHALL be 1 in any cycle with state IDLE, drain_all=1, sb_head_valid=0; else 0.
REQ-023 Load arriving during a store access SHALL wait; load held across drain_all SHALL be granted after drain_all drops.
REQ-024 ld_addr change while ld_req high and not yet captured SHALL use the value present at capture cycle.

Reset
REQ-025 RST high SHALL asynchronously force IDLE, dc_req=0, dc_we=0, dc_addr=0, dc_wdata=0, sb_pop_head=0, ld_grant=0, drain_busy=0, drain_done=0, starve counter=0.
REQ-026 RST mid-access SHALL drop dc_req without pop or grant; the store entry stays in the buffer.

Configuration
REQ-027 Macro STORE_DRAIN_STARVE_GUARD_EN defined: 4-bit counter increments on each load capture while sb_head_valid=1, clears on store capture or sb_head_valid=0; force_store=1 when counter>=STARVE_LIMIT.
REQ-028 Macro undefined: no counter, force_store=0, loads always win IDLE arbitration except under drain_all.

Verification
REQ-029 Single store, addr 0x1234 data 0xBEEF, ack 1 cycle after req -> dc_we=1 write of 0xBEEF@0x1234, one sb_pop_head pulse, back to IDLE.
REQ-030 ld_req and sb_head_valid same cycle, guard off -> load served first, ld_grant pulse, then store issued.
REQ-031 Guard on, STARVE_LIMIT=2, ld_req held high, head valid -> sequence load, load, store, load.
REQ-032 drain_all with 3 stores queued and ld_req high -> 3 writes and pops, no load, drain_done=1 after last pop; load granted after drain_all drops.
REQ-033 dc_ack delayed 5 cycles -> dc_* outputs stable for all 5 cycles, single pop.
REQ-034 RST asserted in ST_WAIT -> dc_req=0 immediately, no sb_pop_head; after release store is re-issued.
